// File: rtl/data_pack_pkg.sv
// Shared definitions for the byte-stream word assembler.
//   state_e    : assembler FSM states (IDLE / ACCUM / STALL)
//   BYTE_W     : width of one input beat / output lane
//   LANES      : lanes per output word
//   WORD_W     : output word width
//   CNT_W      : width of lane counter and group-size code k
//   keep_mask  : tkeep for a word whose highest filled lane is 'count'
package data_pack_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    STALL = 2'd2
  } state_e;

  // Lanes 0..count are valid; equivalent to (1 << (count+1)) - 1.
  function automatic logic [LANES-1:0] keep_mask(input logic [CNT_W-1:0] count);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (i <= int'(count));
    return m;
  endfunction
endpackage

// File: rtl/word_out_reg.sv
// Output holding register for the assembled-word AXI-Stream master.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   load                 : capture word/keep/last this edge (only asserted
//                          when the slot is empty or draining)
//   word, keep, last     : completed word to present downstream
//   m_axis_tready        : downstream accept
//   m_axis_tdata/tkeep/tlast/tvalid : registered stream outputs
// Contents only change on load, so the AXI hold rule is met as long as the
// caller never loads while tvalid & !tready.
module word_out_reg
  import data_pack_pkg::*;
#(
  parameter int W = WORD_W,
  parameter int N = LANES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic [N-1:0] keep,
  input  logic         last,
  input  logic         m_axis_tready,
  output logic [W-1:0] m_axis_tdata,
  output logic [N-1:0] m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= word;
      m_axis_tkeep  <= keep;
      m_axis_tlast  <= last;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_word_assembler.sv
// Assembles groups of (k+1) bytes from an 8-bit AXI-Stream into 32-bit words
// with byte-lane keep; partial words are flushed on tlast.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   k              : bytes per word minus one, latched at packet start
//   s_axis_*       : byte input stream (tdata/tvalid/tready/tlast)
//   m_axis_*       : word output stream (tdata/tkeep/tvalid/tready/tlast),
//                    lane 0 holds the first byte
//   pkt_words      : (PKT_WORD_CNT_EN only) words in the last completed
//                    packet, saturating at 16'hFFFF
// Optional feature macro: PKT_WORD_CNT_EN.
module stream_word_assembler
  import data_pack_pkg::*;
#(
  parameter int IN_WIDTH  = BYTE_W,
  parameter int MAX_BYTES = LANES,
  parameter int OUT_WIDTH = IN_WIDTH * MAX_BYTES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_W-1:0]     k,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic [MAX_BYTES-1:0] m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
`ifdef PKT_WORD_CNT_EN
  , output logic [15:0]        pkt_words
`endif
);
  state_e               state;
  logic [CNT_W-1:0]     cnt, k_lat, k_eff, pend_cnt;
  logic [OUT_WIDTH-1:0] acc, word_nx, load_word;
  logic [MAX_BYTES-1:0] load_keep;
  logic                 pend_last, load_last;
  logic                 accept, slot_free, done, load;

  assign s_axis_tready = (state != STALL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  // In IDLE the incoming byte opens a packet, so the live k applies to it.
  assign k_eff         = (state == IDLE) ? k : k_lat;
  assign done          = accept && ((cnt == k_eff) || s_axis_tlast);

  // Lane 0 starts a fresh word so lanes above the last byte stay zero.
  always_comb begin
    word_nx = (cnt == '0) ? '0 : acc;
    word_nx[cnt*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
  end

  // A stalled word takes priority; no byte is accepted while stalled.
  always_comb begin
    load      = 1'b0;
    load_word = word_nx;
    load_keep = keep_mask(cnt);
    load_last = s_axis_tlast;
    if (state == STALL) begin
      load      = slot_free;
      load_word = acc;
      load_keep = keep_mask(pend_cnt);
      load_last = pend_last;
    end else begin
      load      = done && slot_free;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      k_lat     <= '0;
      acc       <= '0;
      pend_cnt  <= '0;
      pend_last <= 1'b0;
    end else if (state == STALL) begin
      if (slot_free) state <= pend_last ? IDLE : ACCUM;
    end else if (accept) begin
      if (state == IDLE) k_lat <= k;
      acc <= word_nx;
      if (done) begin
        cnt <= '0;
        if (slot_free) begin
          state <= s_axis_tlast ? IDLE : ACCUM;
        end else begin
          state     <= STALL;
          pend_cnt  <= cnt;
          pend_last <= s_axis_tlast;
        end
      end else begin
        cnt   <= cnt + 1'b1;
        state <= ACCUM;
      end
    end
  end

  word_out_reg #(.W(OUT_WIDTH), .N(MAX_BYTES)) u_out (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .word         (load_word),
    .keep         (load_keep),
    .last         (load_last),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid)
  );

`ifdef PKT_WORD_CNT_EN
  // words_in_pkt counts handed-off words before the tlast word.
  logic [15:0] words_in_pkt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_in_pkt <= '0;
      pkt_words    <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tlast) begin
        pkt_words    <= (words_in_pkt == 16'hFFFF) ? 16'hFFFF : words_in_pkt + 16'd1;
        words_in_pkt <= '0;
      end else if (words_in_pkt != 16'hFFFF) begin
        words_in_pkt <= words_in_pkt + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_stream_word_assembler.sv
module tb_stream_word_assembler;
  logic        clk = 0, reset_n = 0;
  logic [1:0]  k = 0;
  logic [7:0]  s_tdata = 0;
  logic        s_tvalid = 0, s_tlast = 0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready = 1;
`ifdef PKT_WORD_CNT_EN
  logic [15:0] pkt_words;
`endif

  stream_word_assembler dut (
    .clk(clk), .reset_n(reset_n), .k(k),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
`ifdef PKT_WORD_CNT_EN
    , .pkt_words(pkt_words)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] kp; logic l; } word_t;
  word_t exp_q[$], obs_q[$];
  word_t w, prev_w;
  int    out_cyc[$];
  int    vec = 0, mis = 0, cyc = 0;
  // reference model state: bytes of the word being built, latched group size
  logic [31:0] cur = 0;
  int    nbytes = 0, klat = 0;
  bit    pkt_start = 1, prev_hold = 0;
  bit    track = 0;
  int    tready_low = 0, acc_bytes = 0, acc_at_low = -1;
  int    rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [31:0] d,
                         input logic [3:0] kp, input logic l);
    if (idx < obs_q.size())
      chk(name, {obs_q[idx].d, obs_q[idx].kp, obs_q[idx].l}, {d, kp, l});
    else begin
      vec++; mis++;
      $display("FAIL %s: got no word %0d expected %0h", name, idx, d);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare process + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete(); cur = 0; nbytes = 0; pkt_start = 1; prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_stable", {m_tdata, m_tkeep, m_tlast}, {prev_w.d, prev_w.kp, prev_w.l});
      end
      if (m_tvalid && m_tready) begin
        obs_q.push_back('{m_tdata, m_tkeep, m_tlast});
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vec++; mis++;
          $display("FAIL unexpected_word: got %0h expected none", m_tdata);
        end else begin
          w = exp_q.pop_front();
          chk("word_data", m_tdata, w.d);
          chk("word_keep", m_tkeep, w.kp);
          chk("word_last", m_tlast, w.l);
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_w = '{m_tdata, m_tkeep, m_tlast};
      if (track && !s_tready) begin
        tready_low++;
        if (acc_at_low < 0) acc_at_low = acc_bytes;
      end
      if (s_tvalid && s_tready) begin
        if (track) acc_bytes++;
        if (pkt_start) klat = int'(k);
        cur[8*nbytes +: 8] = s_tdata;
        nbytes++;
        if (nbytes == klat + 1 || s_tlast) begin
          exp_q.push_back('{cur, 4'((1 << nbytes) - 1), s_tlast});
          cur = 0; nbytes = 0;
        end
        pkt_start = s_tlast;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode != 0) m_tready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    do begin @(negedge clk); n++; end while (!s_tready && n < 200);
    if (!s_tready) begin
      vec++; mis++;
      $display("FAIL send_timeout: got tready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin @(negedge clk); n++; end
    vec++;
    if (n >= 500) begin
      mis++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tlast", m_tlast, 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("rst_tready", s_tready, 1);

    // full 4-byte word
    obs_q.delete(); k = 3;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    drain();
    chk("t1_count", obs_q.size(), 1);
    chk_obs("t1_word", 0, 32'h44332211, 4'hF, 1);

    // k=1, 5 bytes: two full words and a 1-byte flush
    obs_q.delete(); k = 1;
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    drain();
    chk("t2_count", obs_q.size(), 3);
    chk_obs("t2_w0", 0, 32'h0201, 4'h3, 0);
    chk_obs("t2_w1", 1, 32'h0403, 4'h3, 0);
    chk_obs("t2_w2", 2, 32'h05, 4'h1, 1);

    // k=0 full throughput
    obs_q.delete(); out_cyc.delete(); k = 0;
    track = 1; tready_low = 0;
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), i == 7);
    drain(); track = 0;
    chk("t3_tready_low", tready_low, 0);
    chk("t3_count", obs_q.size(), 8);
    if (out_cyc.size() == 8) chk("t3_span", out_cyc[7] - out_cyc[0], 7);
    chk_obs("t3_w3", 3, 32'hA3, 4'h1, 0);
    chk_obs("t3_w7", 7, 32'hA7, 4'h1, 1);

    // backpressure: second word stalls the input
    obs_q.delete(); k = 3; m_tready = 0;
    track = 1; acc_bytes = 0; acc_at_low = -1; tready_low = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7);
      end
      begin
        repeat (10) @(posedge clk); #1; m_tready = 1;
      end
    join
    drain(); track = 0;
    chk("t4_bytes_before_stall", acc_at_low, 8);
    chk("t4_count", obs_q.size(), 2);
    chk_obs("t4_w0", 0, 32'h13121110, 4'hF, 0);
    chk_obs("t4_w1", 1, 32'h17161514, 4'hF, 1);

    // k change mid-packet ignored; next packet back-to-back uses new k
    obs_q.delete(); k = 3;
    send(8'h21, 0); k = 0;
    for (int i = 2; i <= 8; i++) send(8'h20 + 8'(i), i == 8);
    send(8'h31, 0); send(8'h32, 1);
    drain();
    chk("t5_count", obs_q.size(), 4);
    chk_obs("t5_w0", 0, 32'h24232221, 4'hF, 0);
    chk_obs("t5_w1", 1, 32'h28272625, 4'hF, 1);
    chk_obs("t5_w2", 2, 32'h31, 4'h1, 0);
    chk_obs("t5_w3", 3, 32'h32, 4'h1, 1);

    // async reset discards held output and partial word
    m_tready = 0; k = 0;
    send(8'h55, 1);
    k = 3; send(8'h61, 0); send(8'h62, 0);
    chk("t6_pre_tvalid", m_tvalid, 1);
    reset_n = 0; #1;
    chk("t6_rst_tvalid", m_tvalid, 0);
    chk("t6_rst_tdata", m_tdata, 0);
    chk("t6_rst_tkeep", m_tkeep, 0);
    @(posedge clk); #1;
    reset_n = 1; m_tready = 1;
    obs_q.delete(); k = 3;
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 1);
    drain();
    chk("t6_count", obs_q.size(), 1);
    chk_obs("t6_word", 0, 32'hDDCCBBAA, 4'hF, 1);

    // randomized packets, random k each byte, random gaps and ready
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        k = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(8'($urandom), i == len - 1);
      end
    end
    rdy_mode = 0;
    @(posedge clk); #2; m_tready = 1;
    drain();
    chk("final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
